// File: rtl/output_port_arbiter_pkg.sv
// Shared types and helpers for the output-port arbiter: packet type, FSM state
// and modulo pointer arithmetic sized for the largest legal requester count.
package output_port_arbiter_pkg;

   typedef logic [31:0] pkt_t;

   typedef enum logic {IDLE, BURST} arb_state_t;

   localparam int NUM_REQ_MAX = 16;
   localparam int PTR_W       = $clog2(NUM_REQ_MAX);
   localparam int BCNT_W      = 4;

   // Explicit wrap compare so non-power-of-2 requester counts wrap correctly.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                                input int unsigned      n);
      if (32'(p) == n - 1) return '0;
      return p + PTR_W'(1);
   endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// Request side and output-buffer side of the arbiter bundled as one interface.
interface output_port_arbiter_if #(parameter int NUM_REQ = 4);
   import output_port_arbiter_pkg::*;

   logic [NUM_REQ-1:0] cfg_enable;
   logic [NUM_REQ-1:0] req;
   pkt_t               req_pkt [NUM_REQ];
   logic [NUM_REQ-1:0] gnt;
   logic               ob_full;
   logic               ob_pkt_avail;
   pkt_t               ob_pkt;
   logic               busy;

   modport master (
      input  cfg_enable, req, req_pkt, ob_full,
      output gnt, ob_pkt_avail, ob_pkt, busy
   );

   modport slave (
      output cfg_enable, req, req_pkt, ob_full,
      input  gnt, ob_pkt_avail, ob_pkt, busy
   );

endinterface

// File: rtl/output_port_arbiter_rr_priority_picker.sv
// Combinational round-robin scan: first eligible index starting at rr_ptr.
module rr_priority_picker
   import output_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] i_eligible,
   input  logic [PTR_W-1:0]   i_rr_ptr,
   output logic               o_found,
   output logic [PTR_W-1:0]   o_winner
);

   logic [NUM_REQ_MAX-1:0] w_elig_pad;
   logic [PTR_W-1:0]       w_scan;

   assign w_elig_pad = NUM_REQ_MAX'(i_eligible);

   always_comb begin
      o_found  = 1'b0;
      o_winner = '0;
      w_scan   = i_rr_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!o_found && w_elig_pad[w_scan]) begin
            o_found  = 1'b1;
            o_winner = w_scan;
         end
         w_scan = ptr_inc(w_scan, NUM_REQ);
      end
   end

endmodule

// File: rtl/output_port_arbiter.sv
// Round-robin arbiter with optional burst locking feeding one output-buffer FIFO.
// Grant path is combinational; scheduling state (rr_ptr, owner, burst count) is registered.
module output_port_arbiter
   import output_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 1
) (
   input logic                   clock,
   input logic                   reset,
   output_port_arbiter_if.master arb
);

   if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
      $error("output_port_arbiter: NUM_REQ must be in 2..16");
   end
   if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
      $error("output_port_arbiter: MAX_BURST must be in 1..15");
   end

   localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(MAX_BURST);

   arb_state_t             r_state;
   logic [PTR_W-1:0]       r_rr_ptr;
   logic [PTR_W-1:0]       r_owner;
   logic [BCNT_W-1:0]      r_burst_cnt;

   logic [NUM_REQ-1:0]     w_eligible;
   logic [NUM_REQ_MAX-1:0] w_elig_pad;
   logic                   w_found;
   logic [PTR_W-1:0]       w_winner;
   logic                   w_grant;
   logic [PTR_W-1:0]       w_gnt_idx;
   logic                   w_owner_elig;

   assign w_eligible   = arb.req & arb.cfg_enable;
   assign w_elig_pad   = NUM_REQ_MAX'(w_eligible);
   assign w_owner_elig = w_elig_pad[r_owner];

   rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .i_eligible (w_eligible),
      .i_rr_ptr   (r_rr_ptr),
      .o_found    (w_found),
      .o_winner   (w_winner)
   );

   // Full flag and reset both veto any grant; in BURST only the owner may win.
   always_comb begin
      w_grant   = 1'b0;
      w_gnt_idx = w_winner;
      if (!reset && !arb.ob_full) begin
         if (r_state == IDLE) begin
            w_grant = w_found;
         end else begin
            w_grant   = w_owner_elig;
            w_gnt_idx = r_owner;
         end
      end
   end

   always_comb begin
      arb.gnt    = '0;
      arb.ob_pkt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant && (w_gnt_idx == PTR_W'(i))) begin
            arb.gnt[i] = 1'b1;
            arb.ob_pkt = arb.req_pkt[i];
         end
      end
   end

   assign arb.ob_pkt_avail = |arb.gnt;
   assign arb.busy         = (r_state == BURST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_owner     <= '0;
         r_burst_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  if (MAX_BURST == 1) begin
                     r_rr_ptr <= ptr_inc(w_winner, NUM_REQ);
                  end else begin
                     r_owner     <= w_winner;
                     r_burst_cnt <= BCNT_W'(1);
                     r_state     <= BURST;
                  end
               end
            end
            BURST: begin
               // A dropped or disabled owner ends the burst with a bubble cycle.
               if (!w_owner_elig) begin
                  r_rr_ptr <= ptr_inc(r_owner, NUM_REQ);
                  r_state  <= IDLE;
               end else if (w_grant) begin
                  r_burst_cnt <= r_burst_cnt + BCNT_W'(1);
                  if ((r_burst_cnt + BCNT_W'(1)) == BURST_LAST) begin
                     r_rr_ptr <= ptr_inc(r_owner, NUM_REQ);
                     r_state  <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
